// File: rtl/k051937_prio_mixer_if.sv
// Pixel, blanking and CPU register bus between the sprite line-buffer stage, the
// priority mixer and the palette stage.
interface k051937_prio_mixer_if;
  logic        PE_6M;
  logic [11:0] OB;
  logic        SHAD;
  logic        NCBK;
  logic        NVBK;
  logic [8:0]  FIX;
  logic [8:0]  LAYA;
  logic [8:0]  LAYB;
  logic        CS;
  logic        WR;
  logic [1:0]  A;
  logic [7:0]  D;
  logic [10:0] CI;
  logic        SHADOW;
  logic        NBLANK;

  modport master (
    output PE_6M, OB, SHAD, NCBK, NVBK, FIX, LAYA, LAYB, CS, WR, A, D,
    input  CI, SHADOW, NBLANK
  );

  modport slave (
    input  PE_6M, OB, SHAD, NCBK, NVBK, FIX, LAYA, LAYB, CS, WR, A, D,
    output CI, SHADOW, NBLANK
  );
endinterface

// File: rtl/k051937_prio_mixer.sv
// Three-stage sprite/tilemap priority mixer producing palette indices.
// Optional macro PRIO_MIXER_SOLO_EN adds the immediate-effect SOLO debug register at A=3.
module k051937_prio_mixer #(
  parameter int         LAT            = 3,
  parameter logic [7:0] RESET_BACKDROP = 8'h00
) (
  input logic                   clk_24M,
  input logic                   RES,
  k051937_prio_mixer_if.slave   bus
);

  if (LAT != 3) begin : g_lat_check
    $error("k051937_prio_mixer: LAT must be 3");
  end

  typedef enum logic [2:0] {W_FIX, W_A, W_B, W_S, W_BD} win_e;

  logic [2:0] ctrl_pend_q, ctrl_act_q;
  logic [4:0] bd_pend_q, bd_act_q;
  logic [2:0] mask_pend_q, mask_act_q;
  logic       nvbk_q, copy_q;
  logic       wr_en;

  logic [11:0] ob_p0_q;
  logic        shad_p0_q, ncbk_p0_q;
  logic [8:0]  fix_p0_q, laya_p0_q, layb_p0_q;

  logic [10:0] ci_p1_d, ci_p1_q;
  logic        shad_p1_d, shad_p1_q, ncbk_p1_q;

  logic [10:0] ci_p2_q;
  logic        shad_p2_q, nblank_p2_q;

  logic en_fix, en_a, en_b, en_s;
  logic opq_fix, opq_a, opq_b, opq_s;
  win_e win;

  logic unused_ok;
  assign unused_ok = ^{bus.D[7:5], bus.OB[10]};

  assign wr_en = bus.CS & bus.WR;

  // Register file: writes land in pending; active follows one cycle after NVBK falls.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      ctrl_pend_q <= '0;
      bd_pend_q   <= RESET_BACKDROP[4:0];
      mask_pend_q <= 3'b111;
      ctrl_act_q  <= '0;
      bd_act_q    <= RESET_BACKDROP[4:0];
      mask_act_q  <= 3'b111;
      nvbk_q      <= 1'b1;
      copy_q      <= 1'b0;
    end else begin
      nvbk_q <= bus.NVBK;
      copy_q <= nvbk_q & ~bus.NVBK;
      if (copy_q) begin
        ctrl_act_q <= ctrl_pend_q;
        bd_act_q   <= bd_pend_q;
        mask_act_q <= mask_pend_q;
      end
      if (wr_en) begin
        case (bus.A)
          2'd0:    ctrl_pend_q <= bus.D[2:0];
          2'd1:    bd_pend_q   <= bus.D[4:0];
          2'd2:    mask_pend_q <= bus.D[2:0];
          default: ;
        endcase
      end
    end
  end

`ifdef PRIO_MIXER_SOLO_EN
  logic [2:0] solo_q;

  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      solo_q <= '0;
    end else if (wr_en && bus.A == 2'd3) begin
      solo_q <= bus.D[2:0];
    end
  end

  always_comb begin
    en_fix = 1'b1;
    en_a   = 1'b1;
    en_b   = 1'b1;
    en_s   = 1'b1;
    case (solo_q)
      3'd1:    {en_a, en_b, en_s}   = 3'b000;
      3'd2:    {en_fix, en_b, en_s} = 3'b000;
      3'd3:    {en_fix, en_a, en_s} = 3'b000;
      3'd4:    {en_fix, en_a, en_b} = 3'b000;
      default: ;
    endcase
  end
`else
  assign en_fix = 1'b1;
  assign en_a   = 1'b1;
  assign en_b   = 1'b1;
  assign en_s   = 1'b1;
`endif

  assign opq_fix = (|fix_p0_q[3:0])  & mask_act_q[0] & en_fix;
  assign opq_a   = (|laya_p0_q[3:0]) & mask_act_q[1] & en_a;
  assign opq_b   = (|layb_p0_q[3:0]) & mask_act_q[2] & en_b;
  assign opq_s   = (|ob_p0_q[3:0]) & en_s;

  always_comb begin
    win = W_BD;
    if (ob_p0_q[11] && opq_s) begin
      win = W_S;
    end else if (opq_fix) begin
      win = W_FIX;
    end else begin
      case (ctrl_act_q[1:0])
        2'd0:    win = opq_s ? W_S : opq_a ? W_A : opq_b ? W_B : W_BD;
        2'd1:    win = opq_s ? W_S : opq_b ? W_B : opq_a ? W_A : W_BD;
        2'd2:    win = opq_a ? W_A : opq_s ? W_S : opq_b ? W_B : W_BD;
        default: win = opq_b ? W_B : opq_s ? W_S : opq_a ? W_A : W_BD;
      endcase
    end
  end

  always_comb begin
    ci_p1_d = {2'b01, bd_act_q, 4'b0000};
    case (win)
      W_FIX:   ci_p1_d = {2'b00, fix_p0_q};
      W_A:     ci_p1_d = {2'b01, laya_p0_q};
      W_B:     ci_p1_d = {2'b10, layb_p0_q};
      W_S:     ci_p1_d = {1'b1, ob_p0_q[9:0]};
      default: ;
    endcase
    shad_p1_d = shad_p0_q & ctrl_act_q[2] & (win != W_FIX);
  end

  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      ob_p0_q     <= '0;
      shad_p0_q   <= 1'b0;
      ncbk_p0_q   <= 1'b0;
      fix_p0_q    <= '0;
      laya_p0_q   <= '0;
      layb_p0_q   <= '0;
      ci_p1_q     <= '0;
      shad_p1_q   <= 1'b0;
      ncbk_p1_q   <= 1'b0;
      ci_p2_q     <= '0;
      shad_p2_q   <= 1'b0;
      nblank_p2_q <= 1'b0;
    end else if (bus.PE_6M) begin
      // Stage 1: capture upstream pixel
      ob_p0_q   <= bus.OB;
      shad_p0_q <= bus.SHAD;
      ncbk_p0_q <= bus.NCBK;
      fix_p0_q  <= bus.FIX;
      laya_p0_q <= bus.LAYA;
      layb_p0_q <= bus.LAYB;
      // Stage 2: resolved index and shadow
      ci_p1_q   <= ci_p1_d;
      shad_p1_q <= shad_p1_d;
      ncbk_p1_q <= ncbk_p0_q;
      // Stage 3: blanking forces a black, unshadowed output
      ci_p2_q     <= ncbk_p1_q ? ci_p1_q : 11'd0;
      shad_p2_q   <= ncbk_p1_q & shad_p1_q;
      nblank_p2_q <= ncbk_p1_q;
    end
  end

  assign bus.CI     = ci_p2_q;
  assign bus.SHADOW = shad_p2_q;
  assign bus.NBLANK = nblank_p2_q;

endmodule

// File: tb/tb_k051937_prio_mixer.sv
// Directed and randomized checks of the priority mixer against a table-driven reference model.
module tb_k051937_prio_mixer;

  typedef struct packed {
    logic [11:0] ob;
    logic        shad;
    logic        ncbk;
    logic [8:0]  fix;
    logic [8:0]  a;
    logic [8:0]  b;
  } pix_t;

  localparam int LFIX = 0, LA = 1, LB = 2, LS = 3;

  logic clk_24M = 1'b0;
  logic RES     = 1'b1;
  k051937_prio_mixer_if bus ();

  k051937_prio_mixer #(.LAT(3), .RESET_BACKDROP(8'h05)) dut (
    .clk_24M (clk_24M),
    .RES     (RES),
    .bus     (bus)
  );

  always #5 clk_24M = ~clk_24M;

  int vectors = 0;
  int miscompares = 0;

  // reference register state
  logic [2:0] pend_ctrl, act_ctrl, pend_mask, act_mask, solo;
  logic [4:0] pend_bd, act_bd;

  int order_tbl [4][4] = '{'{LFIX, LS, LA, LB},
                           '{LFIX, LS, LB, LA},
                           '{LFIX, LA, LS, LB},
                           '{LFIX, LB, LS, LA}};

  task automatic model_reset();
    pend_ctrl = 3'd0; act_ctrl = 3'd0;
    pend_mask = 3'b111; act_mask = 3'b111;
    pend_bd = 5'h05; act_bd = 5'h05;
    solo = 3'd0;
  endtask

  function automatic logic opaque(pix_t p, int l);
    logic [3:0] col;
    logic       en;
    case (l)
      LFIX:    begin col = p.fix[3:0]; en = act_mask[0]; end
      LA:      begin col = p.a[3:0];   en = act_mask[1]; end
      LB:      begin col = p.b[3:0];   en = act_mask[2]; end
      default: begin col = p.ob[3:0];  en = 1'b1;        end
    endcase
    if (solo >= 3'd1 && solo <= 3'd4 && int'(solo) - 1 != l) en = 1'b0;
    return (col != 4'd0) && en;
  endfunction

  // returns {NBLANK, SHADOW, CI}
  function automatic logic [12:0] model(pix_t p);
    int          seq [4];
    int          n;
    int          w;
    logic [10:0] ci;
    logic        sh;
    n = 0;
    if (p.ob[11]) begin
      seq[0] = LS;
      n = 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (!(p.ob[11] && order_tbl[act_ctrl[1:0]][i] == LS)) begin
        seq[n] = order_tbl[act_ctrl[1:0]][i];
        n++;
      end
    end
    w = -1;
    for (int i = 0; i < 4; i++) begin
      if (w < 0 && opaque(p, seq[i])) w = seq[i];
    end
    case (w)
      LFIX:    ci = 11'(p.fix);
      LA:      ci = 11'h200 + 11'(p.a);
      LB:      ci = 11'h400 + 11'(p.b);
      LS:      ci = 11'h400 + 11'(p.ob[9:0]);
      default: ci = 11'h200 + 11'(act_bd) * 11'd16;
    endcase
    sh = p.shad && act_ctrl[2] && (w != LFIX);
    if (!p.ncbk) return 13'd0;
    return {1'b1, sh, ci};
  endfunction

  task automatic check(string tag, logic [12:0] exp);
    logic [12:0] got;
    got = {bus.NBLANK, bus.SHADOW, bus.CI};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_pix(pix_t p);
    bus.OB = p.ob; bus.SHAD = p.shad; bus.NCBK = p.ncbk;
    bus.FIX = p.fix; bus.LAYA = p.a; bus.LAYB = p.b;
  endtask

  task automatic strobe();
    bus.PE_6M = 1'b1;
    @(posedge clk_24M); #1;
    bus.PE_6M = 1'b0;
    repeat (3) @(posedge clk_24M);
    #1;
  endtask

  task automatic hold_check(string tag, pix_t p);
    set_pix(p);
    repeat (3) strobe();
    check(tag, model(p));
  endtask

  task automatic model_write(logic [1:0] a, logic [7:0] d);
    case (a)
      2'd0: pend_ctrl = d[2:0];
      2'd1: pend_bd   = d[4:0];
      2'd2: pend_mask = d[2:0];
      default: begin
`ifdef PRIO_MIXER_SOLO_EN
        solo = d[2:0];
`endif
      end
    endcase
  endtask

  task automatic cpu_wr(logic [1:0] a, logic [7:0] d);
    bus.CS = 1'b1; bus.WR = 1'b1; bus.A = a; bus.D = d;
    @(posedge clk_24M); #1;
    bus.CS = 1'b0; bus.WR = 1'b0;
    model_write(a, d);
  endtask

  task automatic vblank();
    bus.NVBK = 1'b0;
    repeat (3) @(posedge clk_24M);
    #1;
    act_ctrl = pend_ctrl; act_bd = pend_bd; act_mask = pend_mask;
    bus.NVBK = 1'b1;
    @(posedge clk_24M); #1;
  endtask

  // write presented exactly in the pending-to-active copy cycle
  task automatic vblank_with_write(logic [1:0] a, logic [7:0] d);
    bus.NVBK = 1'b0;
    @(posedge clk_24M); #1;
    bus.CS = 1'b1; bus.WR = 1'b1; bus.A = a; bus.D = d;
    @(posedge clk_24M); #1;
    bus.CS = 1'b0; bus.WR = 1'b0;
    act_ctrl = pend_ctrl; act_bd = pend_bd; act_mask = pend_mask;
    model_write(a, d);
    bus.NVBK = 1'b1;
    repeat (2) @(posedge clk_24M);
    #1;
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    p.ob   = 12'($urandom);
    p.fix  = 9'($urandom);
    p.a    = 9'($urandom);
    p.b    = 9'($urandom);
    if ($urandom_range(0, 2) == 0) p.ob[3:0] = 4'd0;
    if ($urandom_range(0, 1) == 0) p.fix[3:0] = 4'd0;
    if ($urandom_range(0, 2) == 0) p.a[3:0] = 4'd0;
    if ($urandom_range(0, 2) == 0) p.b[3:0] = 4'd0;
    p.shad = 1'($urandom_range(0, 1));
    p.ncbk = ($urandom_range(0, 7) != 0);
    return p;
  endfunction

  task automatic random_run(int n);
    logic [12:0] q [$];
    pix_t        p;
    for (int i = 0; i < n; i++) begin
      p = rand_pix();
      set_pix(p);
      q.push_back(model(p));
      strobe();
      if (q.size() == 3) check("random", q.pop_front());
    end
  endtask

  pix_t p;
  logic [12:0] held;

  initial begin
    bus.PE_6M = 1'b0; bus.CS = 1'b0; bus.WR = 1'b0; bus.A = 2'd0; bus.D = 8'd0;
    bus.NVBK = 1'b1;
    p = '0;
    p.ncbk = 1'b1;
    set_pix(p);
    model_reset();
    repeat (3) @(posedge clk_24M);
    #1;
    check("reset_out", 13'd0);
    RES = 1'b0;
    @(posedge clk_24M); #1;

    // NBLANK rises only once the first strobe's pixel reaches stage 3
    strobe(); check("fill_s1", 13'd0);
    strobe(); check("fill_s2", 13'd0);
    strobe(); check("fill_s3_backdrop", model(p));
    strobe(); check("fill_s4_backdrop", 13'h1250);

    // sprite over layer A, then order change deferred to vblank
    p = '0; p.ncbk = 1'b1; p.ob = 12'h0A7; p.a = 9'h123;
    hold_check("sprite_over_a", p);
    cpu_wr(2'd0, 8'h02);
    hold_check("order_pending", p);
    vblank();
    hold_check("order2_a_wins", p);

    // above-FIX flag
    cpu_wr(2'd0, 8'h00);
    vblank();
    p = '0; p.ncbk = 1'b1; p.fix = 9'h1F1; p.ob = 12'h8A7;
    hold_check("sprite_above_fix", p);
    p.ob = 12'h0A7;
    hold_check("fix_over_sprite", p);

    // shadow and blanking
    cpu_wr(2'd0, 8'h04);
    vblank();
    p = '0; p.ncbk = 1'b1; p.shad = 1'b1; p.ob = 12'h0A7;
    hold_check("shadow_sprite", p);
    p.fix = 9'h1F1;
    hold_check("shadow_fix_wins", p);
    p = '0; p.ncbk = 1'b1; p.shad = 1'b1;
    hold_check("shadow_backdrop", p);
    p.ncbk = 1'b0; p.ob = 12'h0A7;
    hold_check("blanked", p);

    // layer masking and pipeline freeze
    cpu_wr(2'd0, 8'h00);
    cpu_wr(2'd2, 8'h06);
    vblank();
    p = '0; p.ncbk = 1'b1; p.fix = 9'h011; p.b = 9'h044;
    hold_check("fix_masked", p);
    held = model(p);
    set_pix(rand_pix());
    repeat (10) @(posedge clk_24M);
    #1;
    check("freeze", held);

    // write in the copy cycle waits one more frame
    cpu_wr(2'd2, 8'h07);
    vblank();
    p = '0; p.ncbk = 1'b1;
    vblank_with_write(2'd1, 8'h0A);
    hold_check("bd_deferred", p);
    vblank();
    hold_check("bd_applied", p);

    // debug SOLO register (or its absence)
    cpu_wr(2'd3, 8'h03);
    p = '0; p.ncbk = 1'b1; p.fix = 9'h011; p.a = 9'h022; p.b = 9'h033; p.ob = 12'h8A7;
    hold_check("solo_b", p);
    p.b = 9'h030;
    hold_check("solo_b_transparent", p);
    cpu_wr(2'd3, 8'h00);
    hold_check("solo_off", p);

    // randomized frames with randomized register settings
    for (int r = 0; r < 4; r++) begin
      cpu_wr(2'd0, 8'($urandom));
      cpu_wr(2'd1, 8'($urandom));
      cpu_wr(2'd2, 8'($urandom));
      vblank();
      random_run(40);
    end

    // asynchronous reset mid-frame
    cpu_wr(2'd0, 8'h07);
    cpu_wr(2'd1, 8'h1F);
    vblank();
    p = rand_pix(); p.ncbk = 1'b1;
    hold_check("pre_reset", p);
    RES = 1'b1;
    #1;
    check("async_reset", 13'd0);
    model_reset();
    @(posedge clk_24M); #1;
    RES = 1'b0;
    p = '0; p.ncbk = 1'b1; p.ob = 12'h001; p.shad = 1'b1;
    set_pix(p);
    strobe(); check("post_reset_s1", 13'd0);
    strobe(); check("post_reset_s2", 13'd0);
    strobe(); check("post_reset_s3", model(p));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
